// File: rtl/demux2_stream.sv
// One-to-two stream demux: each channel owns a single registered slot (EMPTY/FULL).
// Optional delivered-transfer counters are built when DEMUX2_STREAM_CNT_EN is defined.
//
// state | meaning
// EMPTY | slot holds no data, x_valid=0, accepts input
// FULL  | slot holds data, x_valid=1, accepts input only when drained this cycle
module demux2_stream (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_data,
    input  logic       in_sel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] a_data,
    output logic       a_valid,
    input  logic       a_ready,
    output logic [3:0] b_data,
    output logic       b_valid,
    input  logic       b_ready
`ifdef DEMUX2_STREAM_CNT_EN
    ,
    input  logic       cnt_clr,
    output logic [7:0] a_cnt,
    output logic [7:0] b_cnt
`endif
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

    slot_state_e a_state_q, a_state_d;
    slot_state_e b_state_q, b_state_d;
    logic [3:0]  a_data_q, a_data_d;
    logic [3:0]  b_data_q, b_data_d;

    logic a_ready_in, b_ready_in;
    logic a_load, b_load;
    logic a_out, b_out;

    assign a_ready_in = (a_state_q == EMPTY) || a_ready;
    assign b_ready_in = (b_state_q == EMPTY) || b_ready;
    assign a_load     = in_valid && !in_sel && a_ready_in;
    assign b_load     = in_valid &&  in_sel && b_ready_in;
    assign a_out      = (a_state_q == FULL) && a_ready;
    assign b_out      = (b_state_q == FULL) && b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state_q <= EMPTY;
            b_state_q <= EMPTY;
            a_data_q  <= 4'h0;
            b_data_q  <= 4'h0;
        end else begin
            a_state_q <= a_state_d;
            b_state_q <= b_state_d;
            a_data_q  <= a_data_d;
            b_data_q  <= b_data_d;
        end
    end

    // A simultaneous drain and load keeps the slot FULL, so streaming has no bubble.
    always_comb begin
        a_state_d = a_state_q;
        b_state_d = b_state_q;
        a_data_d  = a_load ? in_data : a_data_q;
        b_data_d  = b_load ? in_data : b_data_q;
        case (a_state_q)
            EMPTY:   if (a_load) a_state_d = FULL;
            FULL:    if (!a_load && a_ready) a_state_d = EMPTY;
            default: a_state_d = EMPTY;
        endcase
        case (b_state_q)
            EMPTY:   if (b_load) b_state_d = FULL;
            FULL:    if (!b_load && b_ready) b_state_d = EMPTY;
            default: b_state_d = EMPTY;
        endcase
    end

    always_comb begin
        a_valid  = (a_state_q == FULL);
        b_valid  = (b_state_q == FULL);
        a_data   = a_data_q;
        b_data   = b_data_q;
        in_ready = in_sel ? b_ready_in : a_ready_in;
    end

`ifdef DEMUX2_STREAM_CNT_EN
    logic [7:0] a_cnt_q, a_cnt_d;
    logic [7:0] b_cnt_q, b_cnt_d;

    // Clear wins over an increment; counts saturate rather than wrap.
    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (cnt_clr) begin
            a_cnt_d = 8'h00;
            b_cnt_d = 8'h00;
        end else begin
            if (a_out && (a_cnt_q != 8'hFF)) a_cnt_d = a_cnt_q + 8'd1;
            if (b_out && (b_cnt_q != 8'hFF)) b_cnt_d = b_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cnt_q <= 8'h00;
            b_cnt_q <= 8'h00;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_cnt = a_cnt_q;
    assign b_cnt = b_cnt_q;
`else
    logic unused_out;
    assign unused_out = a_out ^ b_out;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Scoreboard bench for demux2_stream: stimulus pushes expected channel data, a negedge
// monitor pops on every output handshake; directed checks cover ready, reset and counters.
module tb_demux2_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [3:0] b_data;
    logic       b_valid;
    logic       b_ready;
`ifdef DEMUX2_STREAM_CNT_EN
    logic       cnt_clr;
    logic [7:0] a_cnt;
    logic [7:0] b_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] qa[$];
    logic [3:0] qb[$];

    always #5 clk = ~clk;

    demux2_stream dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_data (in_data),
        .in_sel  (in_sel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a_data  (a_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b_data  (b_data),
        .b_valid (b_valid),
        .b_ready (b_ready)
`ifdef DEMUX2_STREAM_CNT_EN
        ,
        .cnt_clr (cnt_clr),
        .a_cnt   (a_cnt),
        .b_cnt   (b_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output-handshake monitor: every delivered nibble must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (a_valid && a_ready) begin
                if (qa.size() == 0) check("a_unexpected_xfer", 32'(a_data), 32'hDEAD);
                else check("a_stream_data", 32'(a_data), 32'(qa.pop_front()));
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) check("b_unexpected_xfer", 32'(b_data), 32'hDEAD);
                else check("b_stream_data", 32'(b_data), 32'(qb.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] stream [3];
        stream[0] = 4'h1; stream[1] = 4'h2; stream[2] = 4'h3;

        rst_n = 1'b0; in_data = 4'h0; in_sel = 1'b0; in_valid = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0;
`ifdef DEMUX2_STREAM_CNT_EN
        cnt_clr = 1'b0;
`endif
        step(); step();
        check("rst_a_valid", 32'(a_valid), 0);
        check("rst_b_valid", 32'(b_valid), 0);
        check("rst_a_data", 32'(a_data), 0);
        check("rst_b_data", 32'(b_data), 0);
`ifdef DEMUX2_STREAM_CNT_EN
        check("rst_a_cnt", 32'(a_cnt), 0);
        check("rst_b_cnt", 32'(b_cnt), 0);
`endif
        rst_n = 1'b1;
        #1 check("post_rst_ready_sel0", 32'(in_ready), 1);
        in_sel = 1'b1;
        #1 check("post_rst_ready_sel1", 32'(in_ready), 1);
        step();

        // Single load into A
        in_data = 4'h2; in_sel = 1'b0; in_valid = 1'b1;
        #1 check("a_load_ready", 32'(in_ready), 1);
        qa.push_back(4'h2);
        step();
        in_valid = 1'b0;
        check("a_load_valid", 32'(a_valid), 1);
        check("a_load_data", 32'(a_data), 4'h2);
        check("a_load_b_valid", 32'(b_valid), 0);
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        check("a_drained", 32'(a_valid), 0);

        // B stalls, other channel still accepts
        in_data = 4'h3; in_sel = 1'b1; in_valid = 1'b1;
        qb.push_back(4'h3);
        step();
        check("b_load_valid", 32'(b_valid), 1);
        check("b_load_data", 32'(b_data), 4'h3);
        in_data = 4'h9;
        #1 check("b_stall_ready", 32'(in_ready), 0);
        step();
        check("b_stall_hold", 32'(b_data), 4'h3);
        in_sel = 1'b0; in_data = 4'h5;
        #1 check("a_not_blocked_ready", 32'(in_ready), 1);
        qa.push_back(4'h5);
        step();
        in_valid = 1'b0;
        check("a_after_switch_data", 32'(a_data), 4'h5);
        check("b_still_held", 32'(b_data), 4'h3);

        // Both drain in the same cycle
        a_ready = 1'b1; b_ready = 1'b1;
        step();
        check("dual_drain_a", 32'(a_valid), 0);
        check("dual_drain_b", 32'(b_valid), 0);
`ifdef DEMUX2_STREAM_CNT_EN
        check("dual_drain_a_cnt", 32'(a_cnt), 2);
        check("dual_drain_b_cnt", 32'(b_cnt), 1);
`endif
        b_ready = 1'b0;

        // Back-to-back streaming into A with a_ready held
        in_sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = stream[i];
            qa.push_back(stream[i]);
            #1 check("stream_ready", 32'(in_ready), 1);
            if (i > 0) check("stream_a_data", 32'(a_data), 32'(stream[i-1]));
            step();
        end
        in_valid = 1'b0;
        check("stream_last_data", 32'(a_data), 4'h3);
        check("stream_last_valid", 32'(a_valid), 1);
        step();
        check("stream_drained", 32'(a_valid), 0);

        // Stall on B, load A, then in_sel toggling with both stalled
        a_ready = 1'b0;
        in_sel = 1'b1; in_data = 4'h7; in_valid = 1'b1;
        qb.push_back(4'h7);
        step();
        in_sel = 1'b0; in_data = 4'h8;
        #1 check("indep_a_ready", 32'(in_ready), 1);
        qa.push_back(4'h8);
        step();
        in_data = 4'hE; in_sel = 1'b1;
        #1 check("sel_b_stalled", 32'(in_ready), 0);
        in_sel = 1'b0;
        #1 check("sel_a_stalled", 32'(in_ready), 0);
        in_valid = 1'b0;
        a_ready = 1'b1;
        #1 check("sel_a_draining", 32'(in_ready), 1);
        b_ready = 1'b1;
        step();
        check("indep_drain_a", 32'(a_valid), 0);
        check("indep_drain_b", 32'(b_valid), 0);
        b_ready = 1'b0;
`ifdef DEMUX2_STREAM_CNT_EN
        check("cnt_a_before_sat", 32'(a_cnt), 6);
        check("cnt_b_before_sat", 32'(b_cnt), 2);
`endif

        // Long stream into A to push the counter past saturation
        in_sel = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 4'(i);
            qa.push_back(4'(i));
            step();
        end
        in_valid = 1'b0;
        step();
        check("sat_drained", 32'(a_valid), 0);
        check("sat_queue_empty", 32'(qa.size()), 0);
`ifdef DEMUX2_STREAM_CNT_EN
        check("sat_a_cnt", 32'(a_cnt), 8'hFF);
        check("sat_b_cnt", 32'(b_cnt), 2);
        a_ready = 1'b0;
        in_data = 4'hA; in_valid = 1'b1;
        qa.push_back(4'hA);
        step();
        in_valid = 1'b0;
        a_ready = 1'b1; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_prio_a_cnt", 32'(a_cnt), 0);
        check("clr_prio_b_cnt", 32'(b_cnt), 0);
        check("clr_xfer_drained", 32'(a_valid), 0);
`endif

        // Asynchronous reset while A is FULL
        a_ready = 1'b0;
        in_data = 4'hC; in_sel = 1'b0; in_valid = 1'b1;
        qa.push_back(4'hC);
        step();
        in_valid = 1'b0;
        check("pre_areset_valid", 32'(a_valid), 1);
        check("pre_areset_data", 32'(a_data), 4'hC);
        #1 rst_n = 1'b0;
        #1;
        check("areset_a_valid", 32'(a_valid), 0);
        check("areset_a_data", 32'(a_data), 0);
`ifdef DEMUX2_STREAM_CNT_EN
        check("areset_a_cnt", 32'(a_cnt), 0);
`endif
        qa.delete();
        qb.delete();
        step();
        rst_n = 1'b1;
        in_sel = 1'b1;
        #1 check("rerun_ready_sel1", 32'(in_ready), 1);
        in_sel = 1'b0;
        #1 check("rerun_ready_sel0", 32'(in_ready), 1);
        step();
        check("final_a_valid", 32'(a_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
